nonce_gen: RTL and testbench

Upstream stage of nonce_count. It walks a sequence of 32-bit nonce candidates from a seed, issues each one to the hash core over a valid/ready handshake, and waits for the pass/fail result. On a hit it presents the winning nonce to nonce_count with inicio held high. On exhaustion it presents the reserved all-ones word 32'hffffffff, which nonce_count reports as not_found_out.

---
 rtl/nonce_gen.sv | 182 ++++++++++++++++++
 tb/tb_nonce_gen.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nonce_gen.sv
// nonce_gen: walks 32-bit nonce candidates from a seed and offers each one to
// the hash core over valid/ready. It then waits for the pass/fail result. A
// hit is presented with inicio high. Exhaustion presents the reserved word
// 32'hffffffff.
// Optional feature macro: NONCE_GEN_TIMEOUT_EN bounds the wait for hash_done
// to TIMEOUT cycles and drives a sticky timeout_flag.
module nonce_gen #(
    parameter int unsigned STEP      = 1,
    parameter int unsigned MAX_TRIES = 256,
    parameter int unsigned CW        = 16,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic          i_clk_a,
    input  logic          i_reset,
    input  logic          i_start,
    input  logic [0:31]   i_seed,
    input  logic          i_hash_ready,
    input  logic          i_hash_done,
    input  logic          i_hash_ok,
    input  logic          i_ack,
    output logic [0:31]   o_nonce,
    output logic          o_nonce_valid,
    output logic          o_inicio,
    output logic          o_busy,
    output logic [0:CW-1] o_tries,
    output logic          o_timeout_flag
);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StFound,
        StExhaust
    } state_e;

    localparam logic [0:31]   STEP_W   = 32'(STEP);
    localparam logic [0:31]   RESERVED = 32'hffff_ffff;
    localparam logic [0:CW-1] MAX_W    = CW'(MAX_TRIES);
    localparam logic [0:CW-1] ONE_W    = CW'(1);

    state_e        r_state, w_state_d;
    logic [0:31]   r_nonce, w_nonce_d;
    logic          r_valid, w_valid_d;
    logic          r_inicio, w_inicio_d;
    logic          r_busy, w_busy_d;
    logic [0:CW-1] r_tries, w_tries_d;
    logic          r_tflag;

    logic [0:31]   w_inc_raw;
    logic [0:31]   w_inc;
    logic [0:31]   w_seed_fix;
    logic          w_start_acc;
    logic          w_accept;
    logic          w_expire;

    // Next candidate: one extra STEP whenever the plain increment lands on the reserved word.
    always_comb begin
        w_inc_raw  = r_nonce + STEP_W;
        w_inc      = (w_inc_raw == RESERVED) ? (w_inc_raw + STEP_W) : w_inc_raw;
        w_seed_fix = (i_seed == RESERVED) ? 32'h0000_0000 : i_seed;
    end

    assign w_start_acc = (r_state == StIdle) && i_start;
    assign w_accept    = (r_state == StIssue) && i_hash_ready;

`ifdef NONCE_GEN_TIMEOUT_EN
    logic [31:0] r_tmo;

    // Expiry is the cycle the counter would reach zero; a hash_done in that cycle wins.
    assign w_expire = (r_state == StWait) && !i_hash_done && (r_tmo <= 32'd1);

    // Wait-bound down-counter and sticky timeout flag.
    always_ff @(posedge i_clk_a or posedge i_reset) begin
        if (i_reset) begin
            r_tmo   <= 32'd0;
            r_tflag <= 1'b0;
        end else begin
            if (w_accept) begin
                r_tmo <= 32'(TIMEOUT);
            end else if ((r_state == StWait) && (r_tmo != 32'd0)) begin
                r_tmo <= r_tmo - 32'd1;
            end
            if (w_start_acc) begin
                r_tflag <= 1'b0;
            end else if (w_expire) begin
                r_tflag <= 1'b1;
            end
        end
    end
`else
    logic w_unused_tmo;

    assign w_unused_tmo = ^TIMEOUT;
    assign w_expire     = 1'b0;
    assign r_tflag      = 1'b0;
`endif

    // Next-state and registered-output values for the search FSM.
    always_comb begin
        w_state_d  = r_state;
        w_nonce_d  = r_nonce;
        w_valid_d  = r_valid;
        w_inicio_d = r_inicio;
        w_tries_d  = r_tries;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_d = StIssue;
                    w_nonce_d = w_seed_fix;
                    w_tries_d = '0;
                    w_valid_d = 1'b1;
                end
            end
            StIssue: begin
                if (i_hash_ready) begin
                    w_state_d = StWait;
                    w_valid_d = 1'b0;
                    w_tries_d = r_tries + ONE_W;
                end
            end
            StWait: begin
                if (i_hash_done && i_hash_ok) begin
                    w_state_d  = StFound;
                    w_inicio_d = 1'b1;
                end else if ((i_hash_done && !i_hash_ok) || w_expire) begin
                    if (r_tries == MAX_W) begin
                        w_state_d  = StExhaust;
                        w_nonce_d  = RESERVED;
                        w_inicio_d = 1'b1;
                    end else begin
                        w_state_d = StIssue;
                        w_nonce_d = w_inc;
                        w_valid_d = 1'b1;
                    end
                end
            end
            StFound, StExhaust: begin
                // ack has priority over start here because start is ignored outside idle.
                if (i_ack) begin
                    w_state_d  = StIdle;
                    w_inicio_d = 1'b0;
                    w_nonce_d  = '0;
                end
            end
            default: begin
                w_state_d  = StIdle;
                w_nonce_d  = '0;
                w_valid_d  = 1'b0;
                w_inicio_d = 1'b0;
            end
        endcase
        w_busy_d = (w_state_d != StIdle);
    end

    // State and output registers.
    always_ff @(posedge i_clk_a or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= StIdle;
            r_nonce  <= '0;
            r_valid  <= 1'b0;
            r_inicio <= 1'b0;
            r_busy   <= 1'b0;
            r_tries  <= '0;
        end else begin
            r_state  <= w_state_d;
            r_nonce  <= w_nonce_d;
            r_valid  <= w_valid_d;
            r_inicio <= w_inicio_d;
            r_busy   <= w_busy_d;
            r_tries  <= w_tries_d;
        end
    end

    assign o_nonce        = r_nonce;
    assign o_nonce_valid  = r_valid;
    assign o_inicio       = r_inicio;
    assign o_busy         = r_busy;
    assign o_tries        = r_tries;
    assign o_timeout_flag = r_tflag;

endmodule

// File: tb/tb_nonce_gen.sv
// Directed self-checking bench for nonce_gen (STEP=1, MAX_TRIES=4, TIMEOUT=8).
module tb_nonce_gen;

    logic        clk_a;
    logic        reset;
    logic        start;
    logic [0:31] seed;
    logic        hash_ready;
    logic        hash_done;
    logic        hash_ok;
    logic        ack;
    logic [0:31] nonce;
    logic        nonce_valid;
    logic        inicio;
    logic        busy;
    logic [0:15] tries;
    logic        timeout_flag;

    int n_cmp = 0;
    int n_bad = 0;

    logic [0:31] exp3 [4];

    nonce_gen #(
        .STEP      (1),
        .MAX_TRIES (4),
        .CW        (16),
        .TIMEOUT   (8)
    ) dut (
        .i_clk_a        (clk_a),
        .i_reset        (reset),
        .i_start        (start),
        .i_seed         (seed),
        .i_hash_ready   (hash_ready),
        .i_hash_done    (hash_done),
        .i_hash_ok      (hash_ok),
        .i_ack          (ack),
        .o_nonce        (nonce),
        .o_nonce_valid  (nonce_valid),
        .o_inicio       (inicio),
        .o_busy         (busy),
        .o_tries        (tries),
        .o_timeout_flag (timeout_flag)
    );

    initial clk_a = 1'b0;
    always #5 clk_a = ~clk_a;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk_a);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        seed       = '0;
        hash_ready = 1'b0;
        hash_done  = 1'b0;
        hash_ok    = 1'b0;
        ack        = 1'b0;
        exp3[0] = 32'hffff_fffd;
        exp3[1] = 32'hffff_fffe;
        exp3[2] = 32'h0000_0000;
        exp3[3] = 32'h0000_0001;
        tick();
        tick();
        chk("rst_nonce", nonce, 0);
        chk("rst_valid", nonce_valid, 0);
        chk("rst_inicio", inicio, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tries", tries, 0);
        chk("rst_tflag", timeout_flag, 0);
        reset = 1'b0;
        tick();

        // 1: seed 0x10, hit on third result.
        seed  = 32'h0000_0010;
        start = 1'b1;
        tick();
        start      = 1'b0;
        hash_ready = 1'b1;
        chk("t1_first_nonce", nonce, 32'h10);
        chk("t1_first_valid", nonce_valid, 1);
        chk("t1_busy", busy, 1);
        chk("t1_tries0", tries, 0);
        tick();
        chk("t1_acc1_valid", nonce_valid, 0);
        chk("t1_acc1_tries", tries, 1);
        hash_done = 1'b1;
        tick();
        hash_done = 1'b0;
        chk("t1_nonce11", nonce, 32'h11);
        chk("t1_valid11", nonce_valid, 1);
        tick();
        chk("t1_tries2", tries, 2);
        hash_done = 1'b1;
        tick();
        hash_done = 1'b0;
        chk("t1_nonce12", nonce, 32'h12);
        tick();
        chk("t1_tries3", tries, 3);
        hash_done = 1'b1;
        hash_ok   = 1'b1;
        tick();
        hash_done = 1'b0;
        hash_ok   = 1'b0;
        chk("t1_found_nonce", nonce, 32'h12);
        chk("t1_found_inicio", inicio, 1);
        chk("t1_found_tries", tries, 3);
        chk("t1_found_valid", nonce_valid, 0);
        tick();
        chk("t1_found_hold", inicio, 1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("t1_ack_inicio", inicio, 0);
        chk("t1_ack_nonce", nonce, 0);
        chk("t1_ack_busy", busy, 0);
        chk("t1_ack_tries", tries, 3);

        // 2: all fail from 0x100, exhaust after four attempts.
        seed  = 32'h0000_0100;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t2_cand", nonce, 64'h100 + 64'(i));
            chk("t2_valid", nonce_valid, 1);
            tick();
            chk("t2_tries", tries, 64'(i + 1));
            hash_done = 1'b1;
            tick();
            hash_done = 1'b0;
        end
        chk("t2_exh_nonce", nonce, 32'hffff_ffff);
        chk("t2_exh_inicio", inicio, 1);
        chk("t2_exh_valid", nonce_valid, 0);
        chk("t2_exh_tries", tries, 4);
        // start and ack together: ack wins, start dropped.
        start = 1'b1;
        ack   = 1'b1;
        seed  = 32'h0000_0005;
        tick();
        start = 1'b0;
        ack   = 1'b0;
        chk("t2_ack_busy", busy, 0);
        chk("t2_ack_nonce", nonce, 0);
        tick();
        chk("t2_drop_busy", busy, 0);
        chk("t2_drop_valid", nonce_valid, 0);

        // 3: skip of the reserved word.
        seed  = 32'hffff_fffd;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t3_cand", nonce, exp3[i]);
            tick();
            hash_done = 1'b1;
            tick();
            hash_done = 1'b0;
        end
        chk("t3_exh_nonce", nonce, 32'hffff_ffff);
        ack = 1'b1;
        tick();
        ack        = 1'b0;
        hash_ready = 1'b0;
        seed       = 32'hffff_ffff;
        start      = 1'b1;
        tick();
        start = 1'b0;
        chk("t3_seed_ff", nonce, 0);

        // 4: backpressure in ISSUE; spurious done and ack ignored.
        for (int i = 0; i < 5; i++) begin
            hash_done = (i == 1);
            hash_ok   = (i == 1);
            ack       = (i == 3);
            tick();
            chk("t4_valid_hold", nonce_valid, 1);
            chk("t4_nonce_hold", nonce, 0);
            chk("t4_tries_hold", tries, 0);
        end
        hash_done  = 1'b0;
        hash_ok    = 1'b0;
        ack        = 1'b0;
        hash_ready = 1'b1;
        tick();
        chk("t4_acc_tries", tries, 1);
        chk("t4_acc_valid", nonce_valid, 0);
        chk("t4_inicio", inicio, 0);

        // 5: start while busy ignored; async reset mid-WAIT.
        hash_done = 1'b1;
        tick();
        hash_done = 1'b0;
        chk("t5_nonce1", nonce, 1);
        tick();
        chk("t5_tries2", tries, 2);
        start = 1'b1;
        seed  = 32'h0000_0055;
        tick();
        start = 1'b0;
        chk("t5_busy_start_tries", tries, 2);
        chk("t5_busy_start_nonce", nonce, 1);
        chk("t5_busy_start_valid", nonce_valid, 0);
        reset = 1'b1;
        #1;
        chk("t5_rst_nonce", nonce, 0);
        chk("t5_rst_tries", tries, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_valid", nonce_valid, 0);
        tick();
        reset = 1'b0;
        seed  = 32'h0000_0020;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t5_restart_nonce", nonce, 32'h20);
        chk("t5_restart_tries", tries, 0);
        chk("t5_restart_valid", nonce_valid, 1);

        // 6: hash_done never returns.
        tick();
        chk("t6_wait_tries", tries, 1);
`ifdef NONCE_GEN_TIMEOUT_EN
        for (int i = 0; i < 7; i++) tick();
        chk("t6_pre_nonce", nonce, 32'h20);
        chk("t6_pre_valid", nonce_valid, 0);
        chk("t6_pre_flag", timeout_flag, 0);
        tick();
        chk("t6_to_nonce", nonce, 32'h21);
        chk("t6_to_valid", nonce_valid, 1);
        chk("t6_to_flag", timeout_flag, 1);
        tick();
        hash_done = 1'b1;
        hash_ok   = 1'b1;
        tick();
        hash_done = 1'b0;
        hash_ok   = 1'b0;
        chk("t6_found_flag", timeout_flag, 1);
        ack = 1'b1;
        tick();
        ack   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t6_start_clr_flag", timeout_flag, 0);
`else
        for (int i = 0; i < 20; i++) tick();
        chk("t6_stay_nonce", nonce, 32'h20);
        chk("t6_stay_valid", nonce_valid, 0);
        chk("t6_stay_busy", busy, 1);
        chk("t6_stay_flag", timeout_flag, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
